// File: rtl/word_entry_buffer_pkg.sv
// Shared definitions for the word entry path (entry buffer, display driver, game logic).
// Holds the edit-state enum, ASCII control/printable codes and default word geometry.
// No logic here; consumers import word_entry_buffer_pkg::*.
package word_entry_buffer_pkg;

    typedef enum logic {
        EDIT      = 1'b0,
        COMMITTED = 1'b1
    } state_e;

    localparam logic [7:0] PAD_CHAR = 8'h20;  // space, value of an empty slot
    localparam logic [7:0] BS_CHAR  = 8'h08;  // backspace
    localparam logic [7:0] TAB_CHAR = 8'h09;  // commit key
    localparam logic [7:0] PRINT_LO = 8'h20;  // lowest printable code
    localparam logic [7:0] PRINT_HI = 8'h7E;  // highest printable code

    localparam int DEFAULT_DEPTH  = 10;
    localparam int DEFAULT_CHAR_W = 8;

endpackage

// File: rtl/word_entry_buffer_ascii_classify.sv
// Classifies one keyboard code as backspace, commit or printable.
// Purely combinational, zero latency.
// No flow control; outputs follow char_i directly.
module ascii_classify
    import word_entry_buffer_pkg::*;
#(
    parameter int                 CHAR_W      = DEFAULT_CHAR_W,
    parameter logic [CHAR_W-1:0]  BS_CODE     = CHAR_W'(BS_CHAR),
    parameter logic [CHAR_W-1:0]  COMMIT_CODE = CHAR_W'(TAB_CHAR)
) (
    input  logic [CHAR_W-1:0] char_i,
    output logic              is_bs_o,
    output logic              is_commit_o,
    output logic              is_printable_o
);

    assign is_bs_o        = (char_i == BS_CODE);
    assign is_commit_o    = (char_i == COMMIT_CODE);
    // Printable range is fixed ASCII space..tilde regardless of the control codes chosen.
    assign is_printable_o = (char_i >= CHAR_W'(PRINT_LO)) && (char_i <= CHAR_W'(PRINT_HI));

endmodule

// File: rtl/word_entry_buffer.sv
// Captures typed characters into DEPTH slots with backspace, overflow and commit/compare.
// One-cycle latency from accepted strobe to updated letters/length/pulses.
// No backpressure: one char per strobe; chars outside EDIT or with load low are dropped.
module word_entry_buffer
    import word_entry_buffer_pkg::*;
#(
    parameter int                DEPTH       = DEFAULT_DEPTH,
    parameter int                CHAR_W      = DEFAULT_CHAR_W,
    parameter int                LEN_W       = 4,
    parameter logic [CHAR_W-1:0] PAD_CODE    = CHAR_W'(PAD_CHAR),
    parameter logic [CHAR_W-1:0] BS_CODE     = CHAR_W'(BS_CHAR),
    parameter logic [CHAR_W-1:0] COMMIT_CODE = CHAR_W'(TAB_CHAR)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    char_valid,
    input  logic [CHAR_W-1:0]       char_in,
    input  logic [DEPTH*CHAR_W-1:0] target,
    output logic [DEPTH*CHAR_W-1:0] letters,
    output logic [LEN_W-1:0]        length,
    output logic                    empty,
    output logic                    full,
    output logic                    committed,
    output logic                    done,
    output logic                    match,
    output logic                    overflow
);

    // Slot 0 sits in the LSBs so the packed array maps straight onto the letters bus.
    logic [DEPTH-1:0][CHAR_W-1:0] slots_q, slots_d;
    logic [LEN_W-1:0]             length_q, length_d;
    state_e                       state_q, state_d;
    logic                         done_q, done_d;
    logic                         match_q, match_d;
    logic                         overflow_q, overflow_d;

    logic is_bs, is_commit, is_printable;
    logic accept;
    logic buf_empty, buf_full;
    logic [LEN_W-1:0] length_m1;

    ascii_classify #(
        .CHAR_W      (CHAR_W),
        .BS_CODE     (BS_CODE),
        .COMMIT_CODE (COMMIT_CODE)
    ) u_classify (
        .char_i         (char_in),
        .is_bs_o        (is_bs),
        .is_commit_o    (is_commit),
        .is_printable_o (is_printable)
    );

    assign accept    = load && char_valid && (state_q == EDIT);
    assign buf_empty = (length_q == '0);
    assign buf_full  = (length_q == LEN_W'(DEPTH));
    assign length_m1 = length_q - LEN_W'(1);

    // Next-state: clear wins over any character; otherwise apply one edit action.
    always_comb begin
        slots_d    = slots_q;
        length_d   = length_q;
        state_d    = state_q;
        done_d     = 1'b0;
        match_d    = match_q;
        overflow_d = 1'b0;
        if (clear) begin
            slots_d  = {DEPTH{PAD_CODE}};
            length_d = '0;
            state_d  = EDIT;
            match_d  = 1'b0;
        end else if (accept) begin
            if (is_bs) begin
                if (!buf_empty) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (LEN_W'(i) == length_m1) slots_d[i] = PAD_CODE;
                    end
                    length_d = length_m1;
                end
            end else if (is_commit) begin
                // Padding is part of the compare, so shorter targets must be space-padded.
                state_d = COMMITTED;
                done_d  = 1'b1;
                match_d = (slots_q == target);
            end else if (is_printable) begin
                if (buf_full) begin
                    overflow_d = 1'b1;
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (LEN_W'(i) == length_q) slots_d[i] = char_in;
                    end
                    length_d = length_q + LEN_W'(1);
                end
            end
        end
    end

    // State register; reset drops the word immediately without waiting for an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slots_q    <= {DEPTH{PAD_CODE}};
            length_q   <= '0;
            state_q    <= EDIT;
            done_q     <= 1'b0;
            match_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            slots_q    <= slots_d;
            length_q   <= length_d;
            state_q    <= state_d;
            done_q     <= done_d;
            match_q    <= match_d;
            overflow_q <= overflow_d;
        end
    end

    assign letters   = slots_q;
    assign length    = length_q;
    assign empty     = buf_empty;
    assign full      = buf_full;
    assign committed = (state_q == COMMITTED);
    assign done      = done_q;
    assign match     = match_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_word_entry_buffer.sv
module tb_word_entry_buffer;

    localparam int DEPTH  = 10;
    localparam int CHAR_W = 8;
    localparam int LEN_W  = 4;
    localparam int W      = DEPTH * CHAR_W;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         clear = 1'b0;
    logic         load = 1'b0;
    logic         char_valid = 1'b0;
    logic [7:0]   char_in = 8'h00;
    logic [W-1:0] target = '0;

    logic [W-1:0]     letters;
    logic [LEN_W-1:0] length;
    logic empty, full, committed, done, match, overflow;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    word_entry_buffer #(.DEPTH(DEPTH), .CHAR_W(CHAR_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .load       (load),
        .char_valid (char_valid),
        .char_in    (char_in),
        .target     (target),
        .letters    (letters),
        .length     (length),
        .empty      (empty),
        .full       (full),
        .committed  (committed),
        .done       (done),
        .match      (match),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model: the word as a queue of characters ----------------
    logic [7:0] m_q[$];
    bit m_comm  = 1'b0;
    bit m_done  = 1'b0;
    bit m_match = 1'b0;
    bit m_ovf   = 1'b0;

    function automatic logic [W-1:0] model_word();
        logic [W-1:0] w;
        for (int i = 0; i < DEPTH; i++)
            w[i*8 +: 8] = (i < m_q.size()) ? m_q[i] : 8'h20;
        return w;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_comm = 0; m_done = 0; m_match = 0; m_ovf = 0;
        end else begin
            m_done = 0;
            m_ovf  = 0;
            if (clear) begin
                m_q.delete();
                m_comm  = 0;
                m_match = 0;
            end else if (load && char_valid && !m_comm) begin
                if (char_in == 8'h08) begin
                    if (m_q.size() > 0) void'(m_q.pop_back());
                end else if (char_in == 8'h09) begin
                    m_comm  = 1;
                    m_done  = 1;
                    m_match = (model_word() == target);
                end else if (char_in >= 8'h20 && char_in <= 8'h7E) begin
                    if (m_q.size() < DEPTH) m_q.push_back(char_in);
                    else m_ovf = 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("letters",   128'(letters),   128'(model_word()));
            check("length",    128'(length),    128'(m_q.size()));
            check("empty",     128'(empty),     128'(m_q.size() == 0));
            check("full",      128'(full),      128'(m_q.size() == DEPTH));
            check("committed", 128'(committed), 128'(m_comm));
            check("done",      128'(done),      128'(m_done));
            check("match",     128'(match),     128'(m_match));
            check("overflow",  128'(overflow),  128'(m_ovf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] c);
        load = 1'b1; char_valid = 1'b1; char_in = c;
        @(posedge clk); #1;
        char_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    localparam logic [W-1:0] ALL_PAD = {DEPTH{8'h20}};
    localparam logic [W-1:0] W_CAT   = 80'h20202020202020544143;
    localparam logic [W-1:0] W_CAR   = 80'h20202020202020524143;

    initial begin
        #12;
        check("reset_letters", 128'(letters), 128'(ALL_PAD));
        check("reset_len",     128'(length),  128'd0);
        check("reset_empty",   128'(empty),   128'd1);
        check("reset_flags",   128'({full, committed, done, match, overflow}), 128'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        cmp_en = 1'b1;

        // CAT
        send(8'h43); send(8'h41); send(8'h54);
        check("cat_letters", 128'(letters), 128'(W_CAT));
        check("cat_len",     128'(length),  128'd3);
        check("cat_ef",      128'({empty, full}), 128'd0);

        // BS then R; control junk and load-low chars are ignored
        send(8'h08); send(8'h52);
        check("car_letters", 128'(letters), 128'(W_CAR));
        send(8'h01);
        load = 1'b0; char_valid = 1'b1; char_in = 8'h41; @(posedge clk); #1; char_valid = 1'b0;
        check("ignored_len", 128'(length), 128'd3);

        // BS on empty buffer
        do_clear();
        send(8'h08);
        check("bs_empty_len", 128'(length), 128'd0);

        // Fill then overflow
        for (int i = 0; i < DEPTH; i++) send(8'h61 + 8'(i));
        check("fill_full", 128'(full), 128'd1);
        send(8'h5A);
        check("ovf_pulse", 128'(overflow), 128'd1);
        check("ovf_slot9", 128'(letters[9*8 +: 8]), 128'h6A);
        check("ovf_len",   128'(length), 128'd10);
        idle(1);
        check("ovf_gone", 128'(overflow), 128'd0);

        // Commit matching word
        do_clear();
        target = W_CAT;
        send(8'h43); send(8'h41); send(8'h54); send(8'h09);
        check("commit_done",  128'({done, match, committed}), 128'b111);
        send(8'h58);
        check("commit_hold", 128'(letters), 128'(W_CAT));
        check("done_gone",   128'({done, match}), 128'b01);
        send(8'h08); send(8'h09);
        check("commit_ignores", 128'({length, done}), 128'({4'd3, 1'b0}));

        // Clear with a simultaneous Q while committed
        clear = 1'b1; load = 1'b1; char_valid = 1'b1; char_in = 8'h51;
        @(posedge clk); #1;
        clear = 1'b0; char_valid = 1'b0;
        check("clear_letters", 128'(letters), 128'(ALL_PAD));
        check("clear_state",   128'({committed, match, length}), 128'd0);

        // Mismatching word
        send(8'h43); send(8'h4F); send(8'h54); send(8'h09);
        check("cot_done_match", 128'({done, match}), 128'b10);

        // Empty commit against all-pad target
        do_clear();
        target = ALL_PAD;
        send(8'h09);
        check("empty_commit", 128'({done, match}), 128'b11);
        do_clear();

        // Async reset mid-word
        send(8'h41); send(8'h42);
        #2; reset = 1'b1; #1;
        check("arst_letters", 128'(letters), 128'(ALL_PAD));
        check("arst_len",     128'(length),  128'd0);
        #3; reset = 1'b0;
        @(posedge clk); #1;
        send(8'h44);
        check("post_rst_slot0", 128'(letters[7:0]), 128'h44);
        idle(2);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/word_entry_buffer.md
Name: word_entry_buffer

Overview:
- Parametrised successor to the fixed 10-letter load stage; captures a typed word, one ASCII character per strobe, into DEPTH character slots.
- Keeps its own write pointer, so no external counter is needed.
- Adds backspace editing, overflow detection, a commit key, and a registered compare against a target word.
- Sits between the keyboard ASCII decoder and the game/display logic, which reads the flat letters bus.

Parameters:
- DEPTH, 10, number of character slots (1..16).
- CHAR_W, 8, bits per character.
- LEN_W, 4, width of length output; must satisfy 2**LEN_W > DEPTH.
- PAD_CODE, 8'h20, value of an empty slot (space).
- BS_CODE, 8'h08, backspace code.
- COMMIT_CODE, 8'h09, commit code (TAB).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush to empty EDIT state.
- load  in  1  capture enable; characters are ignored while low.
- char_valid  in  1  one-cycle strobe, char_in is valid.
- char_in  in  CHAR_W  ASCII code from the keyboard decoder.
- target  in  DEPTH*CHAR_W  word to compare against; slot 0 is in the LSBs.
- letters  out  DEPTH*CHAR_W  buffer contents; slot 0 is in the LSBs.
- length  out  LEN_W  number of filled slots.
- empty  out  1  high when length==0.
- full  out  1  high when length==DEPTH.
- committed  out  1  high while in COMMITTED state.
- done  out  1  one-cycle pulse on commit.
- match  out  1  compare result, valid from the cycle done is high.
- overflow  out  1  one-cycle pulse when a printable character is dropped.

Behaviour:
- Reset (async, reset high):
  - Every slot is PAD_CODE, length=0, state=EDIT.
  - done, match and overflow are 0.
  - empty=1, full=0, committed=0.
- All outputs are registered except empty, full and committed, which decode directly from registered state.
- A character is accepted when load && char_valid && state==EDIT. Accepted characters take effect at the next rising edge (1-cycle latency).
- EDIT handling of an accepted character:
  - BS_CODE with length>0: slot[length-1] <= PAD_CODE, length--.
  - BS_CODE with length==0: no change, no pulse.
  - COMMIT_CODE: state moves to COMMITTED, done=1 for one cycle, and match <= (letters == target) across all DEPTH slots. Padding takes part in the compare, so a shorter target must be space-padded. An empty buffer may commit.
  - Printable code (8'h20..8'h7E) with length<DEPTH: slot[length] <= char_in, length++.
  - Printable code with length==DEPTH: character dropped, overflow=1 for one cycle, no other change.
  - Any other code: ignored.
- COMMITTED state:
  - All characters are ignored, including BS_CODE and COMMIT_CODE.
  - letters and match hold their values.
- clear (any state):
  - Next edge: all slots PAD_CODE, length=0, state=EDIT, match=0.
  - clear has priority over a simultaneous accepted character. That character is discarded and produces no done or overflow pulse.
- Since one character is processed per cycle, no two events ever coincide.
- load low has no effect on stored state, and does not block clear.
- Asserting reset mid-word discards all contents immediately, without waiting for a clock edge.

Decomposition:
- Shared package holds:
  - State enum: EDIT, COMMITTED.
  - ASCII constants: PAD, BS, TAB, printable lower/upper bounds.
  - Default DEPTH and CHAR_W, reused by the display and game blocks.
- One natural sub-module, ascii_classify: combinational, maps char_in to is_bs / is_commit / is_printable. It is shared with the display driver.

Test Plan:
- Reset then type "C","A","T" (8'h43,8'h41,8'h54) -> letters slots 0..2 = 43,41,54, slots 3..9 = 20; length=3; empty=0, full=0.
- Type "CAT", BS, "R" -> slots 0..2 = 43,41,52; length=3; BS on an empty buffer -> no change, no pulse.
- Type 10 letters, then "Z" (8'h5A) -> full=1, overflow pulse for exactly 1 cycle, slot 9 unchanged, length=10.
- target="CAT" space-padded, type "CAT", TAB -> done pulses 1 cycle, match=1, committed=1. A following "X" is ignored. Repeat with "COT" -> match=0.
- In COMMITTED, assert clear together with char_valid "Q" -> next cycle: state EDIT, all slots 20, length=0, match=0, no Q stored.
- Type "AB", assert reset between clock edges -> outputs go to reset values immediately; releasing reset and typing "D" -> slot 0 = 44.
